gpio_debounce: RTL and testbench

Input conditioning stage placed between the chip pads and the `gpio_in_i` port of the APB4 GPIO controller. Each pad input is synchronised, and then a per-pin stability counter filters it, driven by a shared clock prescaler. The filtered level goes to the controller, where edge and level interrupts are generated. A per-pin bypass forwards the synchronised input unfiltered, and a per-pin one-cycle change pulse is provided for wake-up logic.

---
 rtl/gpio_pkg.sv | 19 +
 rtl/gpio_debounce_cell.sv | 78 +++++++
 rtl/gpio_debounce.sv | 68 ++++++
 tb/tb_gpio_debounce.sv | 363 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gpio_pkg.sv
// Shared definitions for the GPIO block: default widths and the debounce
// cell's per-cycle action encoding.
package gpio_pkg;

    localparam int unsigned GPIO_DEF_NUM      = 32;
    localparam int unsigned GPIO_DB_CNT_WIDTH = 8;
    localparam int unsigned GPIO_DB_DIV_WIDTH = 16;

    typedef logic [31:0] gpio_vec_t;

    typedef enum logic [2:0] {
        ActHold,
        ActClear,
        ActCommit,
        ActCount,
        ActBypass
    } db_act_e;

endpackage

// File: rtl/gpio_debounce_cell.sv
// One pin of the debouncer: a stability counter that accepts a new level only
// after it has persisted for thr_i prescaler ticks.
module gpio_debounce_cell
    import gpio_pkg::*;
#(
    parameter int unsigned CNT_WIDTH = GPIO_DB_CNT_WIDTH
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 sync1_i,
    input  logic                 tick_i,
    input  logic                 flt_en_i,
    input  logic [CNT_WIDTH-1:0] thr_i,
    output logic                 filt_o,
    output logic                 chg_o
);

    logic                 filt_q, filt_d;
    logic                 chg_q, chg_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    db_act_e              act;

    always_comb begin
        act = ActHold;
        if (!flt_en_i) begin
            act = ActBypass;
        end else if (sync1_i == filt_q) begin
            act = ActClear;
        end else if (cnt_q >= thr_i) begin
            // Compared every cycle, so lowering thr_i commits at once.
            act = ActCommit;
        end else if (tick_i) begin
            act = ActCount;
        end
    end

    always_comb begin
        filt_d = filt_q;
        cnt_d  = cnt_q;
        unique case (act)
            ActBypass: begin
                filt_d = sync1_i;
                cnt_d  = '0;
            end
            ActClear: begin
                cnt_d = '0;
            end
            ActCommit: begin
                filt_d = sync1_i;
                cnt_d  = '0;
            end
            ActCount: begin
                cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
            end
            default: begin
                filt_d = filt_q;
                cnt_d  = cnt_q;
            end
        endcase
        chg_d = filt_d ^ filt_q;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            filt_q <= 1'b0;
            chg_q  <= 1'b0;
            cnt_q  <= '0;
        end else begin
            filt_q <= filt_d;
            chg_q  <= chg_d;
            cnt_q  <= cnt_d;
        end
    end

    assign filt_o = filt_q;
    assign chg_o  = chg_q;

endmodule

// File: rtl/gpio_debounce.sv
// Pad input conditioning ahead of the GPIO controller: two-flop synchroniser,
// shared free-running prescaler and one debounce cell per pin.
module gpio_debounce
    import gpio_pkg::*;
#(
    parameter int unsigned GPIO_NUM  = GPIO_DEF_NUM,
    parameter int unsigned CNT_WIDTH = GPIO_DB_CNT_WIDTH,
    parameter int unsigned DIV_WIDTH = GPIO_DB_DIV_WIDTH
) (
    input  logic                 pclk_i,
    input  logic                 presetn_i,
    input  logic [GPIO_NUM-1:0]  pad_in_i,
    input  logic [GPIO_NUM-1:0]  flt_en_i,
    input  logic [DIV_WIDTH-1:0] div_i,
    input  logic [CNT_WIDTH-1:0] thr_i,
    output logic [GPIO_NUM-1:0]  gpio_in_o,
    output logic [GPIO_NUM-1:0]  chg_o
);

    if (GPIO_NUM < 1 || GPIO_NUM > 32) begin : g_bad_num
        $error("gpio_debounce: GPIO_NUM must be in 1..32");
    end

    logic [GPIO_NUM-1:0]  sync0_q, sync0_d;
    logic [GPIO_NUM-1:0]  sync1_q, sync1_d;
    logic [DIV_WIDTH-1:0] div_cnt_q, div_cnt_d;
    logic                 tick;

    // Using >= rather than == gives an immediate tick when div_i is lowered
    // below the running count, so the prescaler never has to wrap first.
    always_comb begin
        sync0_d   = pad_in_i;
        sync1_d   = sync0_q;
        tick      = (div_cnt_q >= div_i);
        div_cnt_d = tick ? '0 : div_cnt_q + 1'b1;
    end

    always_ff @(posedge pclk_i or negedge presetn_i) begin
        if (!presetn_i) begin
            sync0_q   <= '0;
            sync1_q   <= '0;
            div_cnt_q <= '0;
        end else begin
            sync0_q   <= sync0_d;
            sync1_q   <= sync1_d;
            div_cnt_q <= div_cnt_d;
        end
    end

    for (genvar i = 0; i < int'(GPIO_NUM); i++) begin : g_pin
        gpio_debounce_cell #(
            .CNT_WIDTH(CNT_WIDTH)
        ) u_cell (
            .clk_i    (pclk_i),
            .rst_ni   (presetn_i),
            .sync1_i  (sync1_q[i]),
            .tick_i   (tick),
            .flt_en_i (flt_en_i[i]),
            .thr_i    (thr_i),
            .filt_o   (gpio_in_o[i]),
            .chg_o    (chg_o[i])
        );
    end

    chg_matches_edge : assert property (@(posedge pclk_i) disable iff (!presetn_i)
        chg_o == (gpio_in_o ^ $past(gpio_in_o)));

endmodule

// File: tb/tb_gpio_debounce.sv
// Directed bench for gpio_debounce with hand-computed latencies, plus a
// cycle model for the concurrent prescaled scenario.
module tb_gpio_debounce;
    import gpio_pkg::*;

    logic        pclk_i;
    logic        presetn_i;
    gpio_vec_t   pad_in_i;
    gpio_vec_t   flt_en_i;
    logic [15:0] div_i;
    logic [7:0]  thr_i;
    gpio_vec_t   gpio_in_o;
    gpio_vec_t   chg_o;

    int checks;
    int failures;

    // Reference model state
    gpio_vec_t   m_sync0, m_sync1, m_filt, m_chg;
    logic [15:0] m_div;
    logic [7:0]  m_cnt [32];

    gpio_debounce #(
        .GPIO_NUM  (32),
        .CNT_WIDTH (8),
        .DIV_WIDTH (16)
    ) dut (
        .pclk_i    (pclk_i),
        .presetn_i (presetn_i),
        .pad_in_i  (pad_in_i),
        .flt_en_i  (flt_en_i),
        .div_i     (div_i),
        .thr_i     (thr_i),
        .gpio_in_o (gpio_in_o),
        .chg_o     (chg_o)
    );

    initial begin
        pclk_i = 1'b0;
        forever #5 pclk_i = ~pclk_i;
    end

    task automatic edge_wait();
        @(posedge pclk_i);
        #1;
    endtask

    task automatic do_reset();
        presetn_i = 1'b0;
        edge_wait();
        edge_wait();
        presetn_i = 1'b1;
    endtask

    task automatic model_reset();
        m_sync0 = '0;
        m_sync1 = '0;
        m_filt  = '0;
        m_chg   = '0;
        m_div   = '0;
        for (int i = 0; i < 32; i++) m_cnt[i] = '0;
    endtask

    // Advances the model by one edge using the inputs held during the last cycle.
    task automatic model_update();
        logic      tk;
        gpio_vec_t nf;
        tk = (m_div >= div_i);
        nf = m_filt;
        for (int i = 0; i < 32; i++) begin
            if (!flt_en_i[i]) begin
                nf[i] = m_sync1[i];
                m_cnt[i] = '0;
            end else if (m_sync1[i] == m_filt[i]) begin
                m_cnt[i] = '0;
            end else if (m_cnt[i] >= thr_i) begin
                nf[i] = m_sync1[i];
                m_cnt[i] = '0;
            end else if (tk && m_cnt[i] != 8'hFF) begin
                m_cnt[i] = m_cnt[i] + 8'd1;
            end
        end
        m_chg   = nf ^ m_filt;
        m_filt  = nf;
        m_div   = tk ? 16'd0 : m_div + 16'd1;
        m_sync1 = m_sync0;
        m_sync0 = pad_in_i;
    endtask

    task automatic test_reset();
        presetn_i = 1'b0;
        pad_in_i  = '1;
        flt_en_i  = '0;
        div_i     = '0;
        thr_i     = '0;
        repeat (3) edge_wait();
        checks++;
        if (gpio_in_o !== 32'h0) begin
            failures++;
            $display("FAIL reset_gpio: got %h want %h", gpio_in_o, 32'h0);
        end
        checks++;
        if (chg_o !== 32'h0) begin
            failures++;
            $display("FAIL reset_chg: got %h want %h", chg_o, 32'h0);
        end
        pad_in_i = '0;
        edge_wait();
        presetn_i = 1'b1;
        repeat (4) edge_wait();
        checks++;
        if (gpio_in_o !== 32'h0 || chg_o !== 32'h0) begin
            failures++;
            $display("FAIL post_reset_idle: got gpio=%h chg=%h want 0/0", gpio_in_o, chg_o);
        end
    endtask

    task automatic test_bypass();
        flt_en_i = '0;
        pad_in_i[0] = 1'b1;
        for (int k = 1; k <= 2; k++) begin
            edge_wait();
            checks++;
            if (gpio_in_o[0] !== 1'b0) begin
                failures++;
                $display("FAIL bypass_early edge%0d: got %b want 0", k, gpio_in_o[0]);
            end
        end
        edge_wait();
        checks++;
        if (gpio_in_o[0] !== 1'b1 || chg_o[0] !== 1'b1) begin
            failures++;
            $display("FAIL bypass_edge3: got gpio=%b chg=%b want 1/1", gpio_in_o[0], chg_o[0]);
        end
        edge_wait();
        checks++;
        if (gpio_in_o[0] !== 1'b1 || chg_o[0] !== 1'b0) begin
            failures++;
            $display("FAIL bypass_edge4: got gpio=%b chg=%b want 1/0", gpio_in_o[0], chg_o[0]);
        end
    endtask

    task automatic test_filtered();
        int rise;
        int pulses;
        flt_en_i = '1;
        div_i    = 16'd0;
        thr_i    = 8'd4;
        repeat (2) edge_wait();
        pad_in_i[5] = 1'b1;
        rise   = 0;
        pulses = 0;
        for (int k = 1; k <= 12; k++) begin
            edge_wait();
            if (chg_o[5]) pulses++;
            if (rise == 0 && gpio_in_o[5]) rise = k;
        end
        checks++;
        if (rise != 7) begin
            failures++;
            $display("FAIL filtered_latency: got %0d want 7", rise);
        end
        checks++;
        if (pulses != 1) begin
            failures++;
            $display("FAIL filtered_pulses: got %0d want 1", pulses);
        end
    endtask

    task automatic test_glitch();
        int hi;
        int pulses;
        int rise;
        hi     = 0;
        pulses = 0;
        pad_in_i[3] = 1'b1;
        for (int k = 0; k < 3; k++) begin
            edge_wait();
            if (gpio_in_o[3]) hi++;
            if (chg_o[3]) pulses++;
        end
        pad_in_i[3] = 1'b0;
        for (int k = 0; k < 15; k++) begin
            edge_wait();
            if (gpio_in_o[3]) hi++;
            if (chg_o[3]) pulses++;
        end
        checks++;
        if (hi != 0) begin
            failures++;
            $display("FAIL glitch_level: got %0d high cycles want 0", hi);
        end
        checks++;
        if (pulses != 0) begin
            failures++;
            $display("FAIL glitch_chg: got %0d pulses want 0", pulses);
        end
        // A full-length latency afterwards shows the counter restarted from 0.
        pad_in_i[3] = 1'b1;
        rise = 0;
        for (int k = 1; k <= 12; k++) begin
            edge_wait();
            if (rise == 0 && gpio_in_o[3]) rise = k;
        end
        checks++;
        if (rise != 7) begin
            failures++;
            $display("FAIL glitch_cnt_cleared: got latency %0d want 7", rise);
        end
    endtask

    task automatic test_prescaled();
        int        rise31;
        int        fall31;
        gpio_vec_t r;
        pad_in_i  = 32'h8000_0000;
        flt_en_i  = 32'hFFFF_00FF;
        div_i     = 16'd9;
        thr_i     = 8'd3;
        presetn_i = 1'b0;
        edge_wait();
        model_reset();
        presetn_i = 1'b1;
        rise31 = 0;
        fall31 = 0;
        for (int n = 1; n <= 320; n++) begin
            edge_wait();
            model_update();
            checks++;
            if (gpio_in_o !== m_filt) begin
                failures++;
                $display("FAIL model_gpio edge%0d: got %h want %h", n, gpio_in_o, m_filt);
            end
            checks++;
            if (chg_o !== m_chg) begin
                failures++;
                $display("FAIL model_chg edge%0d: got %h want %h", n, chg_o, m_chg);
            end
            if (rise31 == 0 && gpio_in_o[31]) begin
                rise31 = n;
                pad_in_i[31] = 1'b0;
            end else if (rise31 != 0 && fall31 == 0 && !gpio_in_o[31]) begin
                fall31 = n;
            end
            if (n == 100) begin
                div_i = 16'd2;
                thr_i = 8'd1;
            end
            if (n == 200) flt_en_i = 32'h00FF_0F0F;
            if (n == 260) thr_i = 8'd0;
            r = $urandom & $urandom & $urandom;
            pad_in_i = pad_in_i ^ (r & 32'h7FFF_FFFF);
        end
        // Prescaler starts at 0 on release: ticks land on edges 10, 20, 30.
        checks++;
        if (rise31 != 31) begin
            failures++;
            $display("FAIL prescaled_rise: got edge %0d want 31", rise31);
        end
        checks++;
        if (fall31 - rise31 != 30) begin
            failures++;
            $display("FAIL prescaled_fall: got latency %0d want 30", fall31 - rise31);
        end
    endtask

    task automatic test_thr_drop();
        int early;
        pad_in_i = '0;
        flt_en_i = '1;
        div_i    = 16'd0;
        thr_i    = 8'd200;
        do_reset();
        repeat (4) edge_wait();
        pad_in_i[1] = 1'b1;
        early = 0;
        for (int k = 1; k <= 50; k++) begin
            edge_wait();
            if (gpio_in_o[1] || chg_o[1]) early++;
        end
        checks++;
        if (early != 0) begin
            failures++;
            $display("FAIL thr_drop_early: got %0d active cycles want 0", early);
        end
        thr_i = 8'd10;
        edge_wait();
        checks++;
        if (gpio_in_o[1] !== 1'b1 || chg_o[1] !== 1'b1) begin
            failures++;
            $display("FAIL thr_drop_commit: got gpio=%b chg=%b want 1/1", gpio_in_o[1], chg_o[1]);
        end
        edge_wait();
        checks++;
        if (gpio_in_o[1] !== 1'b1 || chg_o[1] !== 1'b0) begin
            failures++;
            $display("FAIL thr_drop_single: got gpio=%b chg=%b want 1/0", gpio_in_o[1], chg_o[1]);
        end
    endtask

    task automatic test_reset_mid();
        int   rise;
        logic chg_at_rise;
        thr_i = 8'd6;
        pad_in_i[2] = 1'b1;
        repeat (5) edge_wait();
        checks++;
        if (gpio_in_o !== 32'h0000_0002) begin
            failures++;
            $display("FAIL mid_count_state: got %h want %h", gpio_in_o, 32'h0000_0002);
        end
        presetn_i = 1'b0;
        #1;
        checks++;
        if (gpio_in_o !== 32'h0 || chg_o !== 32'h0) begin
            failures++;
            $display("FAIL async_clear: got gpio=%h chg=%h want 0/0", gpio_in_o, chg_o);
        end
        repeat (2) edge_wait();
        presetn_i = 1'b1;
        rise = 0;
        chg_at_rise = 1'b0;
        for (int k = 1; k <= 14; k++) begin
            edge_wait();
            if (rise == 0 && gpio_in_o != 32'h0) begin
                rise = k;
                chg_at_rise = (chg_o == 32'h0000_0006);
            end
        end
        checks++;
        if (rise != 9) begin
            failures++;
            $display("FAIL reset_reappear: got edge %0d want 9", rise);
        end
        checks++;
        if (!chg_at_rise || gpio_in_o !== 32'h0000_0006) begin
            failures++;
            $display("FAIL reset_reappear_val: got gpio=%h chg_ok=%b want 00000006/1",
                     gpio_in_o, chg_at_rise);
        end
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        presetn_i = 1'b0;
        pad_in_i  = '0;
        flt_en_i  = '0;
        div_i     = '0;
        thr_i     = '0;
        model_reset();
        test_reset();
        test_bypass();
        test_filtered();
        test_glitch();
        test_prescaled();
        test_thr_drop();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
